line_window_gen: RTL and testbench

- Upstream neighbour of the conv stage inside imageProcessTop.
- Accepts the raw 8-bit pixel stream from the AXI-Stream slave side and stores it in four rotating line buffers.
- Emits one 3x3 pixel window (72 bits) per cycle to conv.
- Raises a one-cycle interrupt each time a full output line has been generated, so the host can push another input line.

---
 rtl/line_window_pkg.sv | 16 +
 rtl/line_buffer.sv | 40 ++++
 rtl/line_window_gen.sv | 109 ++++++++++
 tb/tb_line_window_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_window_pkg.sv
// Shared constants, FSM state type and line-index helper for line_window_gen.
package line_window_pkg;

  localparam int unsigned NUM_LB  = 4;
  localparam int unsigned WIN_DIM = 3;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned WIN_W   = 72;

  typedef enum logic {IDLE, READ} state_e;

  // Two-bit arithmetic gives the mod-4 wrap for free.
  function automatic logic [1:0] lb_idx(input logic [1:0] base, input logic [1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage with a 3-pixel combinational read at ptr..ptr+2.
// With LWG_ZERO_PAD_EN defined, columns past the right edge read as zero instead of replicating.
module line_buffer
  import line_window_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512,
  localparam int unsigned PTR_W = $clog2(IMG_WIDTH)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [PTR_W-1:0]           wr_ptr,
  input  logic [PIX_W-1:0]           wr_data,
  input  logic [PTR_W-1:0]           rd_ptr,
  output logic [WIN_DIM*PIX_W-1:0]   rd_data
);

  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(IMG_WIDTH - 1);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [PTR_W:0]   col;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // IMG_WIDTH is a power of two, so the extra top bit of col flags "past the right edge".
  always_comb begin
    rd_data = '0;
    col     = '0;
    for (int k = 0; k < WIN_DIM; k++) begin
      col = {1'b0, rd_ptr} + (PTR_W + 1)'(k);
`ifdef LWG_ZERO_PAD_EN
      rd_data[k*PIX_W +: PIX_W] = col[PTR_W] ? '0 : mem[col[PTR_W-1:0]];
`else
      rd_data[k*PIX_W +: PIX_W] = col[PTR_W] ? mem[LAST_COL] : mem[col[PTR_W-1:0]];
`endif
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Four rotating line buffers feeding a registered 3x3 window stream with end-of-line interrupt.
// Build option LWG_ZERO_PAD_EN selects zero padding at the right edge (see line_buffer).
module line_window_gen
  import line_window_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512,
  localparam int unsigned PTR_W = $clog2(IMG_WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PIX_W-1:0] i_pixel_data,
  input  logic             i_pixel_data_valid,
  output logic [WIN_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_intr,
  output logic             o_overflow
);

  localparam int unsigned      CNT_W     = PTR_W + 3;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_LB * IMG_WIDTH);
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(WIN_DIM * IMG_WIDTH);
  localparam logic [PTR_W-1:0] LAST_COL  = PTR_W'(IMG_WIDTH - 1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]       wr_sel, rd_sel;
  logic [CNT_W-1:0] fill_cnt;
  state_e           state, state_next;
  logic             rd_en, rd_last, wr_en;

  logic [WIN_DIM*PIX_W-1:0] lb_rd [NUM_LB];
  logic [WIN_W-1:0]         window;

  // A full store still takes a write when a read frees a slot in the same cycle.
  assign wr_en = i_pixel_data_valid && ((fill_cnt != FULL_CNT) || rd_en);

  for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
    line_buffer #(
      .IMG_WIDTH (IMG_WIDTH)
    ) u_lb (
      .clk     (i_clk),
      .wr_en   (wr_en && (wr_sel == 2'(i))),
      .wr_ptr  (wr_ptr),
      .wr_data (i_pixel_data),
      .rd_ptr  (rd_ptr),
      .rd_data (lb_rd[i])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (fill_cnt >= START_CNT) state_next = READ;
      READ: if (rd_ptr == LAST_COL)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = (state == READ);
    rd_last = rd_en && (rd_ptr == LAST_COL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      wr_sel     <= '0;
      rd_ptr     <= '0;
      rd_sel     <= '0;
      fill_cnt   <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wr_ptr == LAST_COL) wr_sel <= wr_sel + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (rd_last) rd_sel <= rd_sel + 1'b1;
      if (wr_en && !rd_en)      fill_cnt <= fill_cnt + 1'b1;
      else if (!wr_en && rd_en) fill_cnt <= fill_cnt - 1'b1;
      if (i_pixel_data_valid && !wr_en) o_overflow <= 1'b1;
    end
  end

  // Row r of the window comes from the r-th oldest line, starting at rd_sel.
  always_comb begin
    window = '0;
    for (int r = 0; r < WIN_DIM; r++) begin
      window[r*WIN_DIM*PIX_W +: WIN_DIM*PIX_W] = lb_rd[lb_idx(rd_sel, 2'(r))];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      if (rd_en) o_pixel_data <= window;
      o_pixel_data_valid <= rd_en;
      o_intr             <= rd_last;
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen with IMG_WIDTH=8: a line-level reference model fills a
// scoreboard of expected windows that is drained as the DUT emits them.
module tb_line_window_gen;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic [71:0] win_out;
  logic        win_valid;
  logic        intr;
  logic        ovf;

  always #5 clk = ~clk;

  line_window_gen #(
    .IMG_WIDTH (W)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pixel_data       (pix_in),
    .i_pixel_data_valid (pix_valid),
    .o_pixel_data       (win_out),
    .o_pixel_data_valid (win_valid),
    .o_intr             (intr),
    .o_overflow         (ovf)
  );

  typedef struct packed {
    logic [71:0] win;
    logic        intr;
  } exp_t;

  exp_t        exp_q[$];
  logic [71:0] win_log[$];
  int          img[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_intr   = 0;
  int          first_v  = -1;
  int          last_v   = -1;
  bit          sb_en    = 1'b1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int line, input int col);
    if (col > W - 1) begin
`ifdef LWG_ZERO_PAD_EN
      return 8'h00;
`else
      col = W - 1;
`endif
    end
    return 8'(img[line*W + col]);
  endfunction

  function automatic logic [71:0] mkwin(input int b [9]);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'(b[i]);
    return w;
  endfunction

  task automatic push_line(input int n);
    exp_t e;
    for (int c = 0; c < W; c++) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++) e.win[8*(3*r+k) +: 8] = ref_pix(n + r, c + k);
      e.intr = (c == W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (win_valid) begin
      win_log.push_back(win_out);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      if (intr) n_intr++;
      if (sb_en) begin
        if (exp_q.size() == 0) check("unexpected_window", 72'(win_valid), 72'(0));
        else begin
          e = exp_q.pop_front();
          check("window", win_out, e.win);
          check("intr_at_window", 72'(intr), 72'(e.intr));
        end
      end
    end else if (sb_en) begin
      check("intr_without_valid", 72'(intr), 72'(0));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic send(input int v);
    pix_in    = 8'(v);
    pix_valid = 1'b1;
    tick();
    img.push_back(v);
    if ((img.size() % W) == 0 && (img.size() / W) >= 3) push_line(img.size() / W - 3);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    img.delete();
    exp_q.delete();
    tick();
  endtask

  task automatic run_s1(input string tag);
    int arr[9];
    int base;
    base    = win_log.size();
    n_intr  = 0;
    first_v = -1;
    for (int i = 0; i < 24; i++) send(i);
    pix_valid = 1'b0;
    tick();
    check({tag, "_lat1_valid"}, 72'(win_valid), 72'(0));
    tick();
    check({tag, "_lat2_valid"}, 72'(win_valid), 72'(1));
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
    check({tag, "_drain"}, 72'(exp_q.size()), 72'(0));
    tick();
    tick();
    check({tag, "_win_count"}, 72'(win_log.size() - base), 72'(8));
    check({tag, "_intr_count"}, 72'(n_intr), 72'(1));
    check({tag, "_span"}, 72'(last_v - first_v), 72'(7));
    arr = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    check({tag, "_first_win"}, win_log[base], mkwin(arr));
`ifdef LWG_ZERO_PAD_EN
    arr = '{7, 0, 0, 15, 0, 0, 23, 0, 0};
`else
    arr = '{7, 7, 7, 15, 15, 15, 23, 23, 23};
`endif
    check({tag, "_last_win"}, win_log[base + 7], mkwin(arr));
  endtask

  initial begin
    int arr[9];
    int base;
    int intr_before;
    int valid_in_rst;

    rst       = 1'b1;
    pix_in    = 8'h00;
    pix_valid = 1'b0;
    tick();
    tick();
    check("rst_data", win_out, 72'(0));
    check("rst_valid", 72'(win_valid), 72'(0));
    check("rst_intr", 72'(intr), 72'(0));
    check("rst_ovf", 72'(ovf), 72'(0));
    rst = 1'b0;
    tick();

    // Single frame of three lines.
    run_s1("s1");

    // Continuous 32-pixel stream: two output lines, one idle cycle between them.
    do_reset();
    base    = win_log.size();
    n_intr  = 0;
    first_v = -1;
    for (int i = 0; i < 32; i++) send(i);
    pix_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check("s3_drain", 72'(exp_q.size()), 72'(0));
    tick();
    tick();
    check("s3_win_count", 72'(win_log.size() - base), 72'(16));
    check("s3_intr_count", 72'(n_intr), 72'(2));
    check("s3_span", 72'(last_v - first_v), 72'(16));
    check("s3_ovf", 72'(ovf), 72'(0));
    arr = '{8, 9, 10, 16, 17, 18, 24, 25, 26};
    check("s3_line1_first", win_log[base + 8], mkwin(arr));

    // Reset during the 4th window of a line, then a fresh frame.
    do_reset();
    base = win_log.size();
    for (int i = 0; i < 24; i++) send(i);
    pix_valid = 1'b0;
    for (int i = 0; i < 20 && (win_log.size() - base) < 4; i++) tick();
    check("s5_reached_4th", 72'(win_log.size() - base), 72'(4));
    rst = 1'b1;
    exp_q.delete();
    intr_before  = n_intr;
    valid_in_rst = 0;
    tick();
    check("s5_valid_after_rst", 72'(win_valid), 72'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (win_valid) valid_in_rst++;
    end
    check("s5_no_valid_in_rst", 72'(valid_in_rst), 72'(0));
    check("s5_no_intr", 72'(n_intr - intr_before), 72'(0));
    rst = 1'b0;
    img.delete();
    tick();
    run_s1("s5_rerun");

    // Long unbroken stream: each line period gains one pixel, so the store is full after 96
    // pixels and the 97th lands on an idle cycle and is dropped.
    do_reset();
    sb_en = 1'b0;
    for (int i = 0; i < 96; i++) send(i);
    check("ovf_before_full", 72'(ovf), 72'(0));
    send(96);
    check("ovf_set", 72'(ovf), 72'(1));
    pix_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ovf_sticky", 72'(ovf), 72'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
